module_alu_ctrl_fsm: RTL

Sequencer that drives the 16:1 ALU result multiplexer from the board inputs. The operator enters operand A, operand B and the 4-bit ALU opcode one at a time on the switches, confirming each with a load button. The block latches the three values, drives ALUControl and both operands into the ALU datapath, and captures the selected ALU result and a zero flag for display. It sits between the board I/O (switches, buttons) and the ALU/mux datapath.

---
 rtl/module_alu_ctrl_fsm.sv | 136 +++++++++++++
 1 files changed

// File: rtl/module_alu_ctrl_fsm.sv
// Board-facing sequencer: latches operand A, operand B and the ALU opcode from the switches,
// one per load press, then captures the ALU mux result and a zero flag for display.
module module_alu_ctrl_fsm #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] sw_i,
   input  logic             btn_load_i,
   input  logic             btn_clr_i,
   input  logic [WIDTH-1:0] alu_result_i,
   output logic [WIDTH-1:0] operand_a_o,
   output logic [WIDTH-1:0] operand_b_o,
   output logic [3:0]       alu_control_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             result_valid_o,
   output logic [2:0]       state_o
);

   localparam int unsigned OP_W = 4;

   typedef enum logic [2:0] {
      S_WAIT_A  = 3'd0,
      S_WAIT_B  = 3'd1,
      S_WAIT_OP = 3'd2,
      S_EXEC    = 3'd3,
      S_SHOW    = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  op_a_q, op_a_d;
   logic [WIDTH-1:0]  op_b_q, op_b_d;
   logic [OP_W-1:0]   ctl_q, ctl_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic              zero_q, zero_d;
   logic              valid_q, valid_d;

   logic load_meta_q, load_sync_q, load_prev_q;
   logic clr_meta_q, clr_sync_q;
   logic load_pulse;

   // Two-flop synchronizers plus one edge-detect flop on the load button
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         load_meta_q <= 1'b0;
         load_sync_q <= 1'b0;
         load_prev_q <= 1'b0;
         clr_meta_q  <= 1'b0;
         clr_sync_q  <= 1'b0;
      end else begin
         load_meta_q <= btn_load_i;
         load_sync_q <= load_meta_q;
         load_prev_q <= load_sync_q;
         clr_meta_q  <= btn_clr_i;
         clr_sync_q  <= clr_meta_q;
      end
   end

   assign load_pulse = load_sync_q & ~load_prev_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_WAIT_A;
         op_a_q  <= '0;
         op_b_q  <= '0;
         ctl_q   <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         ctl_q   <= ctl_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         valid_q <= valid_d;
      end
   end

   // Clear dominates; a load pulse seen in S_EXEC is ignored, not remembered
   always_comb begin
      state_d = state_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      ctl_d   = ctl_q;
      res_d   = res_q;
      zero_d  = zero_q;
      valid_d = valid_q;
      if (clr_sync_q) begin
         state_d = S_WAIT_A;
         op_a_d  = '0;
         op_b_d  = '0;
         ctl_d   = '0;
         res_d   = '0;
         zero_d  = 1'b0;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            S_WAIT_A: if (load_pulse) begin
               op_a_d  = sw_i;
               state_d = S_WAIT_B;
            end
            S_WAIT_B: if (load_pulse) begin
               op_b_d  = sw_i;
               state_d = S_WAIT_OP;
            end
            S_WAIT_OP: if (load_pulse) begin
               ctl_d   = sw_i[OP_W-1:0];
               state_d = S_EXEC;
            end
            S_EXEC: begin
               res_d   = alu_result_i;
               zero_d  = (alu_result_i == '0);
               valid_d = 1'b1;
               state_d = S_SHOW;
            end
            S_SHOW: if (load_pulse) begin
               valid_d = 1'b0;
               state_d = S_WAIT_A;
            end
            default: state_d = S_WAIT_A;
         endcase
      end
   end

   assign operand_a_o    = op_a_q;
   assign operand_b_o    = op_b_q;
   assign alu_control_o  = ctl_q;
   assign result_o       = res_q;
   assign zero_o         = zero_q;
   assign result_valid_o = valid_q;
   assign state_o        = state_q;

endmodule
